i2s_tx_core: RTL and testbench
==============================

# i2s_tx_core

Parametrised I2S/TDM transmit core: the next generation of the audio output controller. It replaces the fixed free-running clock toggles with programmable MCLK and BCLK dividers. It adds an internal sample FIFO, configurable sample/slot width and channel count (I2S or TDM framing), and frame-atomic underrun handling with a counter. It sits between the memory-side audio fetch logic (sample producer) and the DAC pins.

## Interface
- SAMPLE_WIDTH, 24, bits per audio sample (≤ SLOT_WIDTH)
- SLOT_WIDTH, 32, bit clocks per channel slot
- CHANNELS, 2, slots per frame; 2 = I2S framing, 4/8 = TDM framing
- FIFO_DEPTH, 8, sample FIFO entries (power of 2, ≥ CHANNELS)
- DIV_WIDTH, 8, divider register width

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  run serializer and clocks
- mclk_div  in  DIV_WIDTH  MCLK half-period = mclk_div+1 clk cycles
- bclk_div  in  DIV_WIDTH  BCLK half-period = bclk_div+1 clk cycles
- sample_data  in  SAMPLE_WIDTH  sample, channel order 0..CHANNELS-1
- sample_valid  in  1  producer has sample
- sample_ready  out  1  FIFO not full
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries held
- starved  out  1  one-clk pulse per underrun frame
- underrun_count  out  16  saturating underrun frame count
- i2s_mclock  out  1  master clock
- i2s_clock  out  1  bit clock
- i2s_data  out  1  serial data, MSB first
- i2s_lr  out  1  word select (I2S) / frame sync (TDM)

## Operation
- Reset (rst=0, async): all outputs 0 except sample_ready=1. FIFO is emptied. Counters, slot and bit indices are cleared.
- FIFO: a write occurs when sample_valid && sample_ready. sample_ready = (fifo_level < FIFO_DEPTH). Writes are accepted regardless of enable. A simultaneous push and pop leaves the level unchanged.
- Dividers: mclk_div and bclk_div are latched on the clk where enable rises. Changes while running are ignored.
- MCLK: counter runs 0..mclk_div. i2s_mclock toggles and the counter clears when it reaches mclk_div. MCLK runs only while enable=1 or a frame is in progress.
- BCLK: same scheme using bclk_div. The "bclk_fall" strobe is the clk on which i2s_clock toggles 1→0. All data, lr and index updates happen only on bclk_fall.
- Position (slot s, bit b) advances b 0..SLOT_WIDTH-1, then s 0..CHANNELS-1, then wraps to (0,0).
- At bclk_fall into (s,0):
  - If s=0, the frame is checked. If fifo_level ≥ CHANNELS, the frame is valid. Otherwise it is a zero frame: starved pulses, and underrun_count increments (saturating at 16'hFFFF).
  - For a valid frame, pop one sample per slot into the shift register.
  - A zero frame pops nothing.
- Data: at bit b, output sample bit SAMPLE_WIDTH-1-b for b<SAMPLE_WIDTH, otherwise 0. A zero frame outputs all 0.
- i2s_lr:
  - CHANNELS=2: at (s,b) drive s, except at b=SLOT_WIDTH-1 drive the next slot's value. Word select therefore leads the MSB by one BCLK.
  - CHANNELS>2: drive 1 only at (CHANNELS-1, SLOT_WIDTH-1), else 0.
- Enable fall: the current frame completes through (CHANNELS-1, SLOT_WIDTH-1). The core then halts with i2s_clock, i2s_data, i2s_lr at 0 and indices at (0,0). FIFO contents are retained.
- Enable re-rise mid-drain: the core continues without a gap.

## Timing
- i2s_clock starts low. The first bclk_fall occurs 2·(bclk_div+1) clk after enable rises. The first frame check happens there.
- Outputs are registered. i2s_data and i2s_lr change on the clk of bclk_fall (stable through the BCLK rising edge).
- The pop for slot s occurs on its bclk_fall. fifo_level reflects it the next clk.
- starved is asserted exactly 1 clk, coincident with the slot-0 bclk_fall.
- Async reset mid-frame: outputs drop immediately. A new frame starts cleanly from (0,0) after rst releases and enable is high.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0, sample_ready=1, fifo_level=0. After release, outputs stay 0 while enable=0.
- Dividers: mclk_div=1, bclk_div=3, enable=1 -> i2s_mclock period 4 clk, i2s_clock period 8 clk. First i2s_clock fall at clk 8 after enable.
- I2S frame (defaults): push 24'hA5A5A5, 24'h123456 -> left slot bits A5A5A5 then 8 zeros, right slot 123456 then 8 zeros. i2s_lr rises on left bit 31 and falls on right bit 31. fifo_level 2→0.
- Underrun: one sample in FIFO, enable -> zero frame, starved 1-clk pulse, underrun_count=1, fifo_level stays 1. Push a second sample -> next frame valid.
- FIFO full: enable=0, 9 writes -> fifo_level=8, sample_ready=0 after 8th, 9th ignored. Enable drains in order.
- TDM (CHANNELS=4, SLOT_WIDTH=16, SAMPLE_WIDTH=16): push 4 samples -> slots in order. i2s_lr high only during the last bit of slot 3. Drop rst mid-slot-2 -> immediate zero outputs.

Source files
------------

// File: rtl/i2s_tx_core.sv
// i2s_tx_core: I2S/TDM transmit core. Programmable MCLK/BCLK dividers, a
// sample FIFO feeding a per-slot shift register, and frame-atomic underrun
// handling (a frame either carries CHANNELS samples or is all zeros).
module i2s_tx_core #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int DIV_WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          mclk_div,
    input  logic [DIV_WIDTH-1:0]          bclk_div,
    input  logic [SAMPLE_WIDTH-1:0]       sample_data,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          starved,
    output logic [15:0]                   underrun_count,
    output logic                          i2s_mclock,
    output logic                          i2s_clock,
    output logic                          i2s_data,
    output logic                          i2s_lr
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam logic [SW-1:0] LAST_S  = SW'(CHANNELS - 1);
    localparam logic [BW-1:0] LAST_B  = BW'(SLOT_WIDTH - 1);
    localparam logic [LW-1:0] CH_L    = LW'(CHANNELS);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    // FIFO
    logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           level;
    logic                    push, pop;
    logic [SAMPLE_WIDTH-1:0] head_word;

    // clock generation
    logic [DIV_WIDTH-1:0]    mdiv_q, bdiv_q, mcnt, bcnt;
    logic                    enable_q, started, active, latch, bclk_fall, halt;

    // frame position and serializer
    logic [SW-1:0]           slot, nxt_slot;
    logic [BW-1:0]           bit_idx, nxt_bit;
    logic                    at_last, slot_start, frame_start;
    logic                    frame_ok, frame_ok_now, lr_nxt;
    logic [SAMPLE_WIDTH-1:0] shreg;

    assign sample_ready = (level < DEPTH_L);
    assign fifo_level   = level;
    assign push         = sample_valid && sample_ready;
    assign head_word    = mem[rd_ptr];

    // Clocks run while enabled or while a frame is still draining. The
    // dividers are only captured on a fresh start, so a re-rise during a
    // drain keeps the current timing.
    assign active    = enable || started;
    assign latch     = enable && !enable_q && !started;
    assign bclk_fall = active && !latch && i2s_clock && (bcnt == bdiv_q);
    assign at_last   = started && (slot == LAST_S) && (bit_idx == LAST_B);
    assign halt      = bclk_fall && at_last && !enable;

    assign slot_start   = bclk_fall && !halt && (nxt_bit == '0);
    assign frame_start  = slot_start && (nxt_slot == '0);
    assign frame_ok_now = (level >= CH_L);
    assign pop          = slot_start && (frame_start ? frame_ok_now : frame_ok);

    // Next (slot, bit) position; the first fall after a start lands on (0,0)
    always_comb begin
        nxt_slot = '0;
        nxt_bit  = '0;
        if (started && !at_last) begin
            if (bit_idx == LAST_B) begin
                nxt_slot = slot + 1'b1;
            end else begin
                nxt_slot = slot;
                nxt_bit  = bit_idx + 1'b1;
            end
        end
    end

    // Word select: I2S leads the MSB by one BCLK, TDM pulses on the last bit
    always_comb begin
        lr_nxt = 1'b0;
        if (CHANNELS == 2) begin
            lr_nxt = (nxt_bit == LAST_B) ? (nxt_slot == '0) : (nxt_slot != '0);
        end else begin
            lr_nxt = (nxt_slot == LAST_S) && (nxt_bit == LAST_B);
        end
    end

    // Sample storage; only the pointers need reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sample_data;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // MCLK / BCLK dividers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdiv_q     <= '0;
            bdiv_q     <= '0;
            mcnt       <= '0;
            bcnt       <= '0;
            i2s_mclock <= 1'b0;
            i2s_clock  <= 1'b0;
        end else if (latch) begin
            mdiv_q     <= mclk_div;
            bdiv_q     <= bclk_div;
            mcnt       <= '0;
            bcnt       <= '0;
            i2s_mclock <= 1'b0;
            i2s_clock  <= 1'b0;
        end else if (!active || halt) begin
            mcnt       <= '0;
            bcnt       <= '0;
            i2s_mclock <= 1'b0;
            i2s_clock  <= 1'b0;
        end else begin
            if (mcnt == mdiv_q) begin
                mcnt       <= '0;
                i2s_mclock <= ~i2s_mclock;
            end else begin
                mcnt <= mcnt + 1'b1;
            end
            if (bcnt == bdiv_q) begin
                bcnt      <= '0;
                i2s_clock <= ~i2s_clock;
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Position, frame check, shift register and serial outputs on bclk_fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_q       <= 1'b0;
            started        <= 1'b0;
            slot           <= '0;
            bit_idx        <= '0;
            frame_ok       <= 1'b0;
            shreg          <= '0;
            i2s_data       <= 1'b0;
            i2s_lr         <= 1'b0;
            starved        <= 1'b0;
            underrun_count <= '0;
        end else begin
            enable_q <= enable;
            starved  <= 1'b0;
            if (halt) begin
                started  <= 1'b0;
                slot     <= '0;
                bit_idx  <= '0;
                shreg    <= '0;
                i2s_data <= 1'b0;
                i2s_lr   <= 1'b0;
            end else if (bclk_fall) begin
                started <= 1'b1;
                slot    <= nxt_slot;
                bit_idx <= nxt_bit;
                i2s_lr  <= lr_nxt;
                if (frame_start) begin
                    frame_ok <= frame_ok_now;
                    if (!frame_ok_now) begin
                        starved <= 1'b1;
                        if (underrun_count != 16'hFFFF)
                            underrun_count <= underrun_count + 16'd1;
                    end
                end
                if (slot_start) begin
                    // zero frames load zeros so the slot shifts out silence
                    if (pop) begin
                        i2s_data <= head_word[SAMPLE_WIDTH-1];
                        shreg    <= head_word << 1;
                    end else begin
                        i2s_data <= 1'b0;
                        shreg    <= '0;
                    end
                end else begin
                    i2s_data <= shreg[SAMPLE_WIDTH-1];
                    shreg    <= shreg << 1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_core.sv
// tb_i2s_tx_core: drives an I2S instance (defaults) and a TDM instance
// (4 x 16-bit slots) from shared stimulus and compares every output, every
// clk, against a timeline model: positions derive from the clk count since
// start, frames from a sample queue.
module tb_i2s_tx_core;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  mclk_div = '0;
    logic [7:0]  bclk_div = '0;
    logic [23:0] sample_data = '0;
    logic        sample_valid = 1'b0;

    logic [1:0]       o_ready, o_stv, o_mclk, o_bclk, o_data, o_lr;
    logic [1:0][3:0]  o_level;
    logic [1:0][15:0] o_und;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;

    i2s_tx_core dut0 (
        .clk(clk), .rst(rst), .enable(enable),
        .mclk_div(mclk_div), .bclk_div(bclk_div),
        .sample_data(sample_data), .sample_valid(sample_valid),
        .sample_ready(o_ready[0]), .fifo_level(o_level[0]),
        .starved(o_stv[0]), .underrun_count(o_und[0]),
        .i2s_mclock(o_mclk[0]), .i2s_clock(o_bclk[0]),
        .i2s_data(o_data[0]), .i2s_lr(o_lr[0])
    );

    i2s_tx_core #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(16), .CHANNELS(4)) dut1 (
        .clk(clk), .rst(rst), .enable(enable),
        .mclk_div(mclk_div), .bclk_div(bclk_div),
        .sample_data(sample_data[15:0]), .sample_valid(sample_valid),
        .sample_ready(o_ready[1]), .fifo_level(o_level[1]),
        .starved(o_stv[1]), .underrun_count(o_und[1]),
        .i2s_mclock(o_mclk[1]), .i2s_clock(o_bclk[1]),
        .i2s_data(o_data[1]), .i2s_lr(o_lr[1])
    );

    // model configuration per instance
    int P_C  [2] = '{2, 4};
    int P_SW [2] = '{32, 16};
    int P_SA [2] = '{24, 16};

    // model state
    bit          m_run  [2];
    int          m_t    [2];
    int          m_md   [2];
    int          m_bd   [2];
    bit          m_enq  [2];
    logic [31:0] m_buf  [2][DEPTH];
    int          m_head [2];
    int          m_cnt  [2];
    bit          m_fok  [2];
    logic [31:0] m_cur  [2];
    bit          e_data [2];
    bit          e_lr   [2];
    bit          e_stv  [2];
    bit          e_mclk [2];
    bit          e_bclk [2];
    int          e_und  [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_run[k] = 0;  m_t[k] = 0;   m_md[k] = 0;  m_bd[k] = 0;
        m_enq[k] = 0;  m_head[k] = 0; m_cnt[k] = 0; m_fok[k] = 0;
        m_cur[k] = '0; e_data[k] = 0; e_lr[k] = 0;  e_stv[k] = 0;
        e_mclk[k] = 0; e_bclk[k] = 0; e_und[k] = 0;
    endtask

    // One clk of the reference model, using the inputs the DUT saw at the edge
    task automatic model_step(input int k);
        int p, lvl, g, b, s, fl;
        bit started, push;
        lvl  = m_cnt[k];
        push = sample_valid && (lvl < DEPTH);
        e_stv[k] = 0;
        p = 2 * (m_bd[k] + 1);
        started = m_run[k] && (m_t[k] >= p);
        if (enable && !m_enq[k] && !started) begin
            m_run[k] = 1; m_t[k] = 0;
            m_md[k] = int'(mclk_div); m_bd[k] = int'(bclk_div);
        end else if (m_run[k] && !enable && !started) begin
            m_run[k] = 0; m_t[k] = 0;
        end else if (m_run[k]) begin
            m_t[k]++;
            if (m_t[k] % p == 0) begin
                fl = P_SW[k] * P_C[k];
                g  = m_t[k] / p - 1;
                b  = g % P_SW[k];
                s  = (g / P_SW[k]) % P_C[k];
                if (g > 0 && g % fl == 0 && !enable) begin
                    m_run[k] = 0; m_t[k] = 0; e_data[k] = 0; e_lr[k] = 0;
                end else begin
                    if (g % fl == 0) begin
                        m_fok[k] = (lvl >= P_C[k]);
                        if (!m_fok[k]) begin
                            e_stv[k] = 1;
                            if (e_und[k] < 65535) e_und[k]++;
                        end
                    end
                    if (b == 0) begin
                        m_cur[k] = '0;
                        if (m_fok[k]) begin
                            m_cur[k]  = m_buf[k][m_head[k]];
                            m_head[k] = (m_head[k] + 1) % DEPTH;
                            m_cnt[k]--;
                        end
                    end
                    e_data[k] = (b < P_SA[k]) ? m_cur[k][P_SA[k]-1-b] : 1'b0;
                    if (P_C[k] == 2) e_lr[k] = (b == P_SW[k] - 1) ? (s == 0) : (s == 1);
                    else             e_lr[k] = (s == P_C[k] - 1) && (b == P_SW[k] - 1);
                end
            end
        end
        if (push) begin
            m_buf[k][(m_head[k] + m_cnt[k]) % DEPTH] =
                (k == 0) ? 32'(sample_data) : 32'(sample_data[15:0]);
            m_cnt[k]++;
        end
        m_enq[k]  = enable;
        e_bclk[k] = m_run[k] && ((m_t[k] / (m_bd[k] + 1)) % 2 == 1);
        e_mclk[k] = m_run[k] && ((m_t[k] / (m_md[k] + 1)) % 2 == 1);
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.d%0d.ready", ph, k), 32'(o_ready[k]), 32'(m_cnt[k] < DEPTH));
            chk($sformatf("%s.d%0d.level", ph, k), 32'(o_level[k]), 32'(m_cnt[k]));
            chk($sformatf("%s.d%0d.starved", ph, k), 32'(o_stv[k]), 32'(e_stv[k]));
            chk($sformatf("%s.d%0d.under", ph, k), 32'(o_und[k]), 32'(e_und[k]));
            chk($sformatf("%s.d%0d.mclk", ph, k), 32'(o_mclk[k]), 32'(e_mclk[k]));
            chk($sformatf("%s.d%0d.bclk", ph, k), 32'(o_bclk[k]), 32'(e_bclk[k]));
            chk($sformatf("%s.d%0d.data", ph, k), 32'(o_data[k]), 32'(e_data[k]));
            chk($sformatf("%s.d%0d.lr", ph, k), 32'(o_lr[k]), 32'(e_lr[k]));
        end
    endtask

    task automatic cyc(input string ph);
        @(posedge clk);
        if (rst) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        cyc_n++;
        check_all(ph);
    endtask

    task automatic rnd_inputs();
        enable       = 1'($urandom);
        sample_valid = 1'($urandom);
        sample_data  = 24'($urandom);
        mclk_div     = 8'($urandom_range(0, 3));
        bclk_div     = 8'($urandom_range(0, 2));
    endtask

    // Async reset away from the clock edge, checked immediately, held with
    // random inputs, released at a falling edge with the core idle
    task automatic do_reset(input int hold);
        #2;
        rst = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_all("rst_imm");
        repeat (hold) begin
            rnd_inputs();
            cyc("rst_hold");
        end
        rst = 1'b1;
        enable = 1'b0;
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] cap;
        int nb, first_fall, pv;
        bit prev;

        // reset, then idle with enable low
        do_reset(4);
        repeat (6) cyc("idle");

        // I2S frame with mclk_div=1, bclk_div=3
        sample_valid = 1'b1; sample_data = 24'hA5A5A5; cyc("push");
        sample_data = 24'h123456; cyc("push");
        sample_valid = 1'b0; cyc("push");
        chk("i2s.level_pre", 32'(o_level[0]), 32'd2);
        mclk_div = 8'd1; bclk_div = 8'd3; enable = 1'b1;
        cap = '0; nb = 0; first_fall = -1; prev = 1'b0;
        for (int i = 0; i < 600 && nb < 64; i++) begin
            cyc("i2s");
            if (prev && !o_bclk[0]) begin
                if (first_fall < 0) first_fall = i;
                cap = {cap[62:0], o_data[0]};
                nb++;
            end
            prev = o_bclk[0];
        end
        chk("i2s.falls", 32'(nb), 32'd64);
        chk("i2s.first_fall", 32'(first_fall), 32'd8);
        chk("i2s.left", cap[63:32], 32'hA5A5A500);
        chk("i2s.right", cap[31:0], 32'h12345600);
        enable = 1'b0;
        repeat (20) cyc("i2s_halt");
        chk("i2s.halt_bclk", 32'(o_bclk[0]), 32'd0);
        chk("i2s.level_post", 32'(o_level[0]), 32'd0);

        // underrun: one sample is not a frame
        do_reset(3);
        sample_valid = 1'b1; sample_data = 24'hC0FFEE; cyc("ur_push");
        sample_valid = 1'b0; mclk_div = 8'd0; bclk_div = 8'd0; enable = 1'b1;
        repeat (10) cyc("ur");
        chk("ur.count1", 32'(o_und[0]), 32'd1);
        chk("ur.level1", 32'(o_level[0]), 32'd1);
        sample_valid = 1'b1; sample_data = 24'h5A5A5A; cyc("ur_push2");
        sample_valid = 1'b0;
        repeat (300) cyc("ur2");
        chk("ur.count2", 32'(o_und[0]), 32'd2);
        enable = 1'b0;
        repeat (200) cyc("ur_halt");

        // FIFO full while disabled, then drain in order
        do_reset(3);
        for (int i = 0; i < 9; i++) begin
            sample_valid = 1'b1; sample_data = 24'($urandom);
            cyc("full_push");
        end
        sample_valid = 1'b0;
        cyc("full");
        chk("full.level", 32'(o_level[0]), 32'd8);
        chk("full.ready", 32'(o_ready[0]), 32'd0);
        mclk_div = 8'd0; bclk_div = 8'd0; enable = 1'b1;
        repeat (600) cyc("drain");
        enable = 1'b0;
        repeat (200) cyc("drain_halt");
        chk("full.empty", 32'(o_level[0]), 32'd0);

        // TDM frame, then async reset in the middle of slot 2
        do_reset(3);
        for (int i = 0; i < 4; i++) begin
            sample_valid = 1'b1; sample_data = 24'($urandom);
            cyc("tdm_push");
        end
        sample_valid = 1'b0; mclk_div = 8'd2; bclk_div = 8'd0; enable = 1'b1;
        repeat (70) cyc("tdm");
        do_reset(2);
        chk("tdm.rst_lr", 32'(o_lr[1]), 32'd0);
        enable = 1'b1; bclk_div = 8'd1;
        repeat (300) cyc("tdm_restart");

        // randomized traffic with enable toggles and occasional resets
        pv = 50;
        for (int i = 0; i < 6000; i++) begin
            if (i % 500 == 0) pv = int'($urandom_range(5, 95));
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            sample_valid = ($urandom_range(0, 99) < pv);
            sample_data  = 24'($urandom);
            mclk_div     = 8'($urandom_range(0, 3));
            bclk_div     = 8'($urandom_range(0, 2));
            if ($urandom_range(0, 2499) == 0) begin
                do_reset(2);
                enable = 1'b1;
            end
            cyc("rand");
        end
        enable = 1'b0; sample_valid = 1'b0;
        repeat (1000) cyc("final_halt");
        chk("final.bclk0", 32'(o_bclk[0]), 32'd0);
        chk("final.bclk1", 32'(o_bclk[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
